// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Shares one status LED between NUM_REQ requesters. A round-robin arbiter
//   picks one requester. The LED then shows that requester's blink code:
//   N on/off pulses followed by a dark gap. The LED timing comes from a tick
//   prescaler plus a tick counter.
//
// Ports
//   clk    in   1               system clock
//   rst_n  in   1               asynchronous active-low reset
//   req    in   NUM_REQ         level request per requester
//   code   in   NUM_REQ*CODE_W  pulse count; requester i uses code[i*CODE_W +: CODE_W]
//   abort  in   1               synchronous cancel of the sequence in progress
//   grant  out  NUM_REQ         one-hot requester being served
//   busy   out  1               high whenever a sequence is in progress
//   done   out  1               one-cycle pulse on normal sequence completion
//   io_v   out  1               LED drive, 1 = on
//
// State table
//   state | meaning
//   IDLE  | no sequence; arbitrate on req each edge
//   ON    | LED lit for ON_TICKS ticks
//   OFF   | LED dark for OFF_TICKS ticks between pulses
//   GAP   | LED dark for GAP_TICKS ticks, then done
module led_blink_arbiter #(
  parameter int TICK_DIV  = 2_700_000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 3,
  parameter int GAP_TICKS = 10,
  parameter int NUM_REQ   = 4,
  parameter int CODE_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CODE_W-1:0] code,
  input  logic                      abort,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      done,
  output logic                      io_v
);

  localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
  localparam int PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TCK_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t              state;
  logic [PRE_W-1:0]    pre;
  logic [TCK_W-1:0]    tcnt;
  logic [CODE_W-1:0]   pcnt;
  logic [PTR_W-1:0]    ptr;

  logic                tick;
  logic [TCK_W-1:0]    tcnt_last;
  logic [PTR_W-1:0]    win_idx;
  logic [CODE_W-1:0]   win_code;
  logic [NUM_REQ-1:0]  win_onehot;

  assign tick = (pre == PRE_W'(TICK_DIV - 1));

  // The tick counter never exceeds the last tick index of the current
  // state, so it never goes past MAX_TICKS-1.
  always_comb begin
    tcnt_last = '0;
    case (state)
      ON:      tcnt_last = TCK_W'(ON_TICKS - 1);
      OFF:     tcnt_last = TCK_W'(OFF_TICKS - 1);
      GAP:     tcnt_last = TCK_W'(GAP_TICKS - 1);
      default: tcnt_last = '0;
    endcase
  end

  // Round-robin search: the first set req at ptr+1, ptr+2, ... wraps modulo NUM_REQ.
  always_comb begin
    int   idx;
    logic found;
    win_idx  = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        win_idx = PTR_W'(idx);
        found   = 1'b1;
      end
    end
    win_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == int'(win_idx)) win_code = code[i*CODE_W +: CODE_W];
    end
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      io_v  <= 1'b0;
      pre   <= '0;
      tcnt  <= '0;
      pcnt  <= '0;
      ptr   <= PTR_W'(NUM_REQ - 1);
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        // The pointer keeps the aborted winner, so the rotation continues past it.
        state <= IDLE;
        grant <= '0;
        busy  <= 1'b0;
        io_v  <= 1'b0;
        pre   <= '0;
        tcnt  <= '0;
      end else if (state == IDLE) begin
        if (|req) begin
          grant <= win_onehot;
          ptr   <= win_idx;
          pcnt  <= win_code;
          busy  <= 1'b1;
          pre   <= '0;
          tcnt  <= '0;
          if (win_code == '0) begin
            state <= GAP;
          end else begin
            state <= ON;
            io_v  <= 1'b1;
          end
        end
      end else if (!tick) begin
        pre <= pre + 1'b1;
      end else if (tcnt != tcnt_last) begin
        pre  <= '0;
        tcnt <= tcnt + 1'b1;
      end else begin
        pre  <= '0;
        tcnt <= '0;
        if (state == ON) begin
          state <= OFF;
          io_v  <= 1'b0;
          pcnt  <= pcnt - 1'b1;
        end else if (state == OFF) begin
          if (pcnt != '0) begin
            state <= ON;
            io_v  <= 1'b1;
          end else begin
            state <= GAP;
          end
        end else begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
